// File: rtl/shift_rotate_pipe.sv
// Pipelined shift/rotate unit: log2(WIDTH) registered stages, each applying 2^i when count bit i
// is set. Carry is resolved at the input stage and piped; zero is registered with the result.
module shift_rotate_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] data,
   input  logic [CNT_W-1:0] shiftCount,
   input  logic [2:0]       operation,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero
);

   localparam logic [2:0] OpSll = 3'd0;
   localparam logic [2:0] OpSrl = 3'd1;
   localparam logic [2:0] OpSra = 3'd2;
   localparam logic [2:0] OpRol = 3'd3;
   localparam logic [2:0] OpRor = 3'd4;

   if (CNT_W != $clog2(WIDTH) || WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_param
      $error("shift_rotate_pipe: WIDTH must be a power of two >= 4 and CNT_W left at default");
   end

   logic             advance;
   logic             in_carry;
   logic [CNT_W-1:0] idx_l;
   logic [CNT_W-1:0] idx_r;
   logic             zero_q;

   // Global stall: every stage, bubbles included, holds while the output is blocked.
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   function automatic logic [WIDTH-1:0] stage_shift(input logic [WIDTH-1:0] d,
                                                    input logic [2:0]       op,
                                                    input int unsigned      amt);
      logic [WIDTH-1:0] r;
      case (op)
         OpSll:   r = d << amt;
         OpSrl:   r = d >> amt;
         OpSra:   r = $unsigned($signed(d) >>> amt);
         OpRol:   r = (d << amt) | (d >> (WIDTH - amt));
         OpRor:   r = (d >> amt) | (d << (WIDTH - amt));
         default: r = d;
      endcase
      return r;
   endfunction

   // WIDTH-n and n-1, both taken modulo WIDTH; only used when n != 0.
   assign idx_l = CNT_W'(WIDTH) - shiftCount;
   assign idx_r = shiftCount - CNT_W'(1);

   always_comb begin
      in_carry = 1'b0;
      if (shiftCount != '0) begin
         case (operation)
            OpSll, OpRol:        in_carry = data[idx_l];
            OpSrl, OpSra, OpRor: in_carry = data[idx_r];
            default:             in_carry = 1'b0;
         endcase
      end
   end

   for (genvar i = 0; i < CNT_W; i++) begin : g_stage
      localparam int CW = CNT_W - i;

      logic             v_in;
      logic [WIDTH-1:0] d_in;
      logic [2:0]       op_in;
      logic [CW-1:0]    cnt_in;
      logic             c_in;
      logic [WIDTH-1:0] d_nx;

      logic             v_q;
      logic [WIDTH-1:0] d_q;
      logic             c_q;

      if (i == 0) begin : g_src_in
         assign v_in   = in_valid;
         assign d_in   = data;
         assign op_in  = operation;
         assign cnt_in = shiftCount;
         assign c_in   = in_carry;
      end else begin : g_src_prev
         assign v_in   = g_stage[i-1].v_q;
         assign d_in   = g_stage[i-1].d_q;
         assign op_in  = g_stage[i-1].g_fwd.op_q;
         assign cnt_in = g_stage[i-1].g_fwd.cnt_q;
         assign c_in   = g_stage[i-1].c_q;
      end

      // Bit 0 of the remaining count always belongs to this stage.
      assign d_nx = cnt_in[0] ? stage_shift(d_in, op_in, 32'd1 << i) : d_in;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q <= 1'b0;
            d_q <= '0;
            c_q <= 1'b0;
         end else if (advance) begin
            v_q <= v_in;
            d_q <= d_nx;
            c_q <= c_in;
         end
      end

      if (i < CNT_W - 1) begin : g_fwd
         logic [2:0]    op_q;
         logic [CW-2:0] cnt_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               op_q  <= '0;
               cnt_q <= '0;
            end else if (advance) begin
               op_q  <= op_in;
               cnt_q <= cnt_in[CW-1:1];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_q <= 1'b0;
      end else if (advance) begin
         zero_q <= (g_stage[CNT_W-1].d_nx == '0);
      end
   end

   assign out_valid = g_stage[CNT_W-1].v_q;
   assign result    = g_stage[CNT_W-1].d_q;
   assign carry     = g_stage[CNT_W-1].c_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_shift_rotate_pipe.sv
// Directed and streaming checks for shift_rotate_pipe at WIDTH=8 and WIDTH=32.
module tb_shift_rotate_pipe;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       in_valid, in_ready, out_valid, out_ready, carry, zero;
   logic [7:0] data, result;
   logic [2:0] shift_count, operation;

   logic        in_valid32, in_ready32, out_valid32, carry32, zero32;
   logic [31:0] data32, result32;
   logic [4:0]  shift_count32;
   logic [2:0]  operation32;

   int errors = 0;
   int checks = 0;

   shift_rotate_pipe #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .data(data),
      .shiftCount(shift_count), .operation(operation), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .carry(carry), .zero(zero)
   );

   shift_rotate_pipe #(.WIDTH(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32), .data(data32),
      .shiftCount(shift_count32), .operation(operation32), .out_valid(out_valid32),
      .out_ready(1'b1), .result(result32), .carry(carry32), .zero(zero32)
   );

   // Returns {zero, carry, result} for a w-bit unit.
   function automatic logic [33:0] model(input int w, input logic [31:0] d_in,
                                         input logic [2:0] op, input int n);
      logic [31:0] mask, d, r;
      logic        c;
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      d = d_in & mask;
      r = d;
      c = 1'b0;
      if (op <= 3'd4 && n != 0) begin
         case (op)
            3'd0: begin r = (d << n) & mask; c = d[w-n]; end
            3'd1: begin r = d >> n; c = d[n-1]; end
            3'd2: begin r = (d >> n) | (d[w-1] ? (mask & ~(mask >> n)) : 32'd0); c = d[n-1]; end
            3'd3: begin r = ((d << n) | (d >> (w - n))) & mask; c = r[0]; end
            default: begin r = ((d >> n) | (d << (w - n))) & mask; c = r[w-1]; end
         endcase
      end
      return {(r == 32'd0), c, r};
   endfunction

   // Issue one operand with out_ready=1 and wait for its result.
   task automatic send_one(input logic [2:0] op, input logic [7:0] d, input logic [2:0] n,
                           output logic [7:0] r, output logic c, output logic z, output int lat);
      operation = op; data = d; shift_count = n; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      r = result; c = carry; z = zero;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      int seen;
      #12;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset_result got %h want 00", result); end
      checks++; if ({carry, zero} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {carry, zero}); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      // Fill the pipe with out_ready low, then reset while the first result is held.
      out_ready = 1'b0;
      operation = 3'd2; data = 8'h86; shift_count = 3'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      operation = 3'd0; data = 8'h05; shift_count = 3'd2;
      @(posedge clk); #1;
      operation = 3'd3; data = 8'h64; shift_count = 3'd3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || result !== 8'hF0 || carry !== 1'b1) begin
         errors++; $display("FAIL prereset_hold got v=%b r=%h c=%b want v=1 r=f0 c=1", out_valid, result, carry);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid got %b want 0", out_valid); end
      checks++; if (result !== 8'h00) begin errors++; $display("FAIL midreset_result got %h want 00", result); end
      checks++; if ({carry, zero} !== 2'b00) begin errors++; $display("FAIL midreset_flags got %b want 00", {carry, zero}); end
      @(negedge clk) rst_n = 1'b1;
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL postreset_in_ready got %b want 1", in_ready); end
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL stale_output got %0d results want 0", seen); end
   endtask

   typedef struct packed {
      logic [2:0] op;
      logic [7:0] d;
      logic [2:0] n;
      logic [7:0] r;
      logic       c;
      logic       z;
   } vec_t;

   task automatic test_ops;
      vec_t       vecs [11];
      logic [7:0] r;
      logic       c, z;
      int         lat;
      vecs = '{
         '{3'd0, 8'h05, 3'd2, 8'h14, 1'b0, 1'b0},
         '{3'd0, 8'h05, 3'd3, 8'h28, 1'b0, 1'b0},
         '{3'd2, 8'h86, 3'd3, 8'hF0, 1'b1, 1'b0},
         '{3'd1, 8'h86, 3'd3, 8'h10, 1'b1, 1'b0},
         '{3'd1, 8'h01, 3'd1, 8'h00, 1'b1, 1'b1},
         '{3'd3, 8'h64, 3'd3, 8'h23, 1'b1, 1'b0},
         '{3'd4, 8'h64, 3'd3, 8'h8C, 1'b1, 1'b0},
         '{3'd3, 8'h64, 3'd0, 8'h64, 1'b0, 1'b0},
         '{3'd7, 8'h86, 3'd5, 8'h86, 1'b0, 1'b0},
         '{3'd2, 8'h7F, 3'd7, 8'h00, 1'b1, 1'b1},
         '{3'd0, 8'h81, 3'd7, 8'h80, 1'b0, 1'b0}
      };
      for (int i = 0; i < 11; i++) begin
         send_one(vecs[i].op, vecs[i].d, vecs[i].n, r, c, z, lat);
         checks++; if (lat != 3) begin errors++; $display("FAIL op%0d_latency got %0d want 3", i, lat); end
         checks++; if ({r, c, z} !== {vecs[i].r, vecs[i].c, vecs[i].z}) begin
            errors++;
            $display("FAIL op%0d_result got r=%h c=%b z=%b want r=%h c=%b z=%b",
                     i, r, c, z, vecs[i].r, vecs[i].c, vecs[i].z);
         end
      end
   endtask

   task automatic test_backpressure;
      int         sent, got, cyc;
      logic [7:0] held;
      logic       pend;
      logic [7:0] outs [5];
      out_ready = 1'b0;
      sent = 0;
      for (int k = 0; k < 6; k++) begin
         operation = 3'd0; data = 8'h01; shift_count = 3'(sent); in_valid = 1'b1;
         if (in_ready) sent++;
         @(posedge clk); #1;
      end
      checks++; if (sent != 3) begin errors++; $display("FAIL bp_accepted got %0d want 3", sent); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
      checks++; if (out_valid !== 1'b1 || result !== 8'h01) begin
         errors++; $display("FAIL bp_head got v=%b r=%h want v=1 r=01", out_valid, result);
      end
      got = 0; pend = 1'b0; cyc = 0; held = '0;
      while (got < 5 && cyc < 60) begin
         if (pend) begin
            checks++; if (out_valid !== 1'b1 || result !== held) begin
               errors++; $display("FAIL bp_stable got v=%b r=%h want v=1 r=%h", out_valid, result, held);
            end
         end
         pend = 1'b0;
         out_ready = (cyc % 2) == 1;
         in_valid = (sent < 5); data = 8'h01; shift_count = 3'(sent); operation = 3'd0;
         if (out_valid && !out_ready) begin pend = 1'b1; held = result; end
         if (out_valid && out_ready) begin outs[got] = result; got++; end
         if (in_valid && in_ready) sent++;
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      checks++; if (got != 5) begin errors++; $display("FAIL bp_count got %0d want 5", got); end
      for (int i = 0; i < 5; i++) begin
         checks++; if (outs[i] !== 8'(1 << i)) begin
            errors++; $display("FAIL bp_order%0d got %h want %h", i, outs[i], 8'(1 << i));
         end
      end
   endtask

   task automatic test_full_rate;
      logic [33:0] q8 [$];
      logic [33:0] q32 [$];
      logic [33:0] e;
      logic [31:0] d;
      logic [2:0]  op;
      int          n8, n32, first8, last8, cnt8, first32, last32, cnt32;
      first8 = -1; last8 = -1; cnt8 = 0; first32 = -1; last32 = -1; cnt32 = 0;
      out_ready = 1'b1;
      for (int k = 0; k < 215; k++) begin
         if (out_valid) begin
            if (first8 < 0) first8 = k;
            last8 = k; cnt8++;
            e = (q8.size() != 0) ? q8.pop_front() : 34'h3_FFFF_FFFF;
            checks++; if ({zero, carry, result} !== {e[33], e[32], e[7:0]}) begin
               errors++; $display("FAIL stream8_%0d got z=%b c=%b r=%h want z=%b c=%b r=%h",
                                  cnt8, zero, carry, result, e[33], e[32], e[7:0]);
            end
         end
         if (out_valid32) begin
            if (first32 < 0) first32 = k;
            last32 = k; cnt32++;
            e = (q32.size() != 0) ? q32.pop_front() : 34'h3_FFFF_FFFF;
            checks++; if ({zero32, carry32, result32} !== e) begin
               errors++; $display("FAIL stream32_%0d got z=%b c=%b r=%h want z=%b c=%b r=%h",
                                  cnt32, zero32, carry32, result32, e[33], e[32], e[31:0]);
            end
         end
         if (k < 200) begin
            case (k % 4)
               0:       op = 3'd0;
               1:       op = 3'd2;
               2:       op = 3'd4;
               default: op = 3'(5 + (k / 4) % 3);
            endcase
            d = $urandom; n8 = $urandom_range(0, 7); n32 = $urandom_range(0, 31);
            operation = op; data = d[7:0]; shift_count = 3'(n8); in_valid = 1'b1;
            operation32 = op; data32 = d; shift_count32 = 5'(n32); in_valid32 = 1'b1;
            if (in_ready) q8.push_back(model(8, d, op, n8));
            if (in_ready32) q32.push_back(model(32, d, op, n32));
         end else begin
            in_valid = 1'b0; in_valid32 = 1'b0;
         end
         @(posedge clk); #1;
      end
      checks++; if (cnt8 != 200) begin errors++; $display("FAIL stream8_count got %0d want 200", cnt8); end
      checks++; if (first8 != 3) begin errors++; $display("FAIL stream8_latency got %0d want 3", first8); end
      checks++; if (last8 - first8 != 199) begin errors++; $display("FAIL stream8_rate got span %0d want 199", last8 - first8); end
      checks++; if (cnt32 != 200) begin errors++; $display("FAIL stream32_count got %0d want 200", cnt32); end
      checks++; if (first32 != 5) begin errors++; $display("FAIL stream32_latency got %0d want 5", first32); end
      checks++; if (last32 - first32 != 199) begin errors++; $display("FAIL stream32_rate got span %0d want 199", last32 - first32); end
   endtask

   initial begin
      in_valid = 1'b0; out_ready = 1'b1; data = '0; shift_count = '0; operation = '0;
      in_valid32 = 1'b0; data32 = '0; shift_count32 = '0; operation32 = '0;
      test_reset();
      test_ops();
      test_backpressure();
      test_full_rate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/shift_rotate_pipe.md
Name: shift_rotate_pipe

Overview:
- Parametrised, pipelined successor to the combinational 8-bit shiftRotate unit.
- Generalises data width and adds arithmetic shift, carry/zero flags, and a valid/ready handshake.
- Sits between the operand-select stage and the writeback mux of the datapath.
- Shifts are decomposed into log2(WIDTH) registered stages. Stage i applies a shift/rotate of 2^i when shiftCount bit i is set.

Parameters:
- WIDTH, 8, data width; power of two, >= 4.
- CNT_W, $clog2(WIDTH), shift-count width and pipeline depth. Derived; must not be overridden.

Ports:
- clk  in  1  clock; rising edge active.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept an operand this cycle.
- data  in  WIDTH  operand.
- shiftCount  in  CNT_W  shift/rotate amount, 0..WIDTH-1.
- operation  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 pass-through.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  shifted/rotated value.
- carry  out  1  last bit shifted out (see rules).
- zero  out  1  result == 0.

Behaviour:
- Reset (async, rst_n=0):
  - All stage valid bits, out_valid, result, carry and zero clear to 0 immediately.
  - in_ready=1 while rst_n=1 and out_valid=0.
  - Reset mid-operation discards all in-flight operands; nothing emerges after release.
- Handshake:
  - Transfer in when in_valid && in_ready. Transfer out when out_valid && out_ready.
  - advance = !out_valid || out_ready; in_ready = advance.
  - Global stall: when advance=0 every stage holds, including bubbles.
  - out_valid, result, carry and zero are stable while out_valid && !out_ready.
- Latency: exactly CNT_W cycles from accept to out_valid when unstalled (3 for WIDTH=8). Throughput is 1 per cycle.
- Capacity: CNT_W operands in flight. No loss, no duplication, strict in-order output.
- Stage i: operand, op and remaining count bits are registered and forwarded alongside the valid bit.
- Op semantics, n = shiftCount:
  - SLL: zero-fill from the LSB.
  - SRL: zero-fill from the MSB.
  - SRA: fill with the original data[WIDTH-1].
  - ROL/ROR: no bits lost.
  - Pass-through: result = data and carry = 0; shiftCount is ignored.
- Carry:
  - n=0: carry=0 for all ops.
  - SLL: data[WIDTH-n].
  - SRL/SRA: data[n-1].
  - ROL: result[0].
  - ROR: result[WIDTH-1].
  - Carry may be computed at the input stage and piped through.
- Zero: (result == 0), registered with result. Also applies to pass-through.
- Simultaneous in accept and out accept in the same cycle is legal: the pipeline shifts by one.
- Back-to-back operands with differing ops/counts must not interfere; all control is per-stage.
- in_valid while in_ready=0 has no effect. Source holds its operand, which is not captured.

Test Plan:
- Reset: assert rst_n=0 mid-stream with 2 operands in flight -> out_valid=0, result=0, carry=0, zero=0 immediately. After release, in_ready=1 and no stale result emerges.
- SLL data=0x05 n=2 (out_ready=1) -> 3 cycles later: result=0x14, carry=0, zero=0. SLL 0x05 n=3 -> 0x28, carry=0.
- SRA data=0x86 n=3 -> result=0xF0, carry=1. SRL 0x86 n=3 -> 0x10, carry=1. SRL 0x01 n=1 -> 0x00, carry=1, zero=1.
- ROL data=0x64 n=3 -> 0x23, carry=1. ROR 0x64 n=3 -> 0x8C, carry=1. ROL 0x64 n=0 -> 0x64, carry=0. op=111 data=0x86 n=5 -> 0x86, carry=0.
- Backpressure: stream 5 operands (SLL 0x01 n=0..4) with out_ready=0 -> in_ready drops once out_valid=1 and the pipeline holds 3. Release out_ready -> results 0x01, 0x02, 0x04, 0x08, 0x10 in order with none lost. out_ready toggled every cycle -> outputs stable while stalled.
- Full-rate mixed stream (SLL, SRA, ROR, pass alternating, random data/n, 200 ops) against a reference model -> every result/carry/zero matches, one output per cycle. Repeat with WIDTH=16 (latency 4) and WIDTH=32 (latency 5).
